// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port owner: merges single-cycle pipeline writebacks with
// buffered long-latency results, keeps write-after-write order, and forwards
// every not-yet-committed value to decode.
module reg_writeback_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR   = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         pipe_we,
  input  logic [REG_ADDR-1:0]          pipe_addr,
  input  logic [WIDTH-1:0]             pipe_data,
  input  logic                         sec_valid,
  output logic                         sec_ready,
  input  logic [REG_ADDR-1:0]          sec_addr,
  input  logic [WIDTH-1:0]             sec_data,
  input  logic [REG_ADDR-1:0]          RA1,
  input  logic [REG_ADDR-1:0]          RA2,
  output logic                         fwd1_hit,
  output logic [WIDTH-1:0]             fwd1_data,
  output logic                         fwd2_hit,
  output logic [WIDTH-1:0]             fwd2_data,
  output logic [REG_ADDR-1:0]          A3,
  output logic                         WE3,
  output logic [WIDTH-1:0]             WD3,
  output logic [$clog2(FIFO_DEPTH):0]  pending,
  output logic                         idle
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [REG_ADDR-1:0]   q_addr [FIFO_DEPTH];
  logic [WIDTH-1:0]      q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic pipe_wr;
  logic push;
  logic pop;
  logic fifo_empty;

  // Handshake and arbitration decisions; occupancy alone defines full/empty
  assign fifo_empty = (count == '0);
  assign sec_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign pipe_wr    = pipe_we && (pipe_addr != '0);
  assign push       = sec_valid && sec_ready && (sec_addr != '0);
  assign pop        = !pipe_wr && !fifo_empty;
  assign pending    = count;
  assign idle       = fifo_empty && !WE3;

  // Newest pending value for one read address: live FIFO entries beat WD3
  function automatic logic [WIDTH:0] lookup(input logic [REG_ADDR-1:0] ra);
    logic [WIDTH:0]   res;
    logic [PTR_W-1:0] idx;
    res = '0;
    idx = '0;
    if (WE3 && (A3 == ra)) res = {1'b1, WD3};
    // Oldest to newest so the newest live match is the one that sticks
    for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && q_vld[idx] && (q_addr[idx] == ra))
        res = {1'b1, q_data[idx]};
    end
    if (ra == '0) res = '0;
    return res;
  endfunction

  // Decode forwarding from registered state only
  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(RA1);
    {fwd2_hit, fwd2_data} = lookup(RA2);
  end

  // FIFO storage, WAW kill, pointers and the registered RF write port
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
      q_vld <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      WE3   <= 1'b0;
      A3    <= '0;
      WD3   <= '0;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (pipe_wr && (q_addr[i] == pipe_addr)) q_vld[i] <= 1'b0;
      end
      // A same-cycle push is older than the pipe write, so it is born dead
      if (push) begin
        q_addr[tail] <= sec_addr;
        q_data[tail] <= sec_data;
        q_vld[tail]  <= !(pipe_wr && (sec_addr == pipe_addr));
        tail         <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      if (pipe_wr) begin
        WE3 <= 1'b1;
        A3  <= pipe_addr;
        WD3 <= pipe_data;
      end else if (pop && q_vld[head]) begin
        WE3 <= 1'b1;
        A3  <= q_addr[head];
        WD3 <= q_data[head];
      end else begin
        WE3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed self-checking bench for reg_writeback_arbiter.
module tb_reg_writeback_arbiter;

  logic        CLK;
  logic        RST;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [4:0]  A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [2:0]  pending;
  logic        idle;

  int errors = 0;
  int checks = 0;

  reg_writeback_arbiter #(.WIDTH(32), .REG_ADDR(5), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr), .sec_data(sec_data),
    .RA1(RA1), .RA2(RA2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .A3(A3), .WE3(WE3), .WD3(WD3), .pending(pending), .idle(idle)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle and sample just after the active edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we3"}, 32'(WE3), 32'(we));
    if (we) begin
      chk({tag, ".a3"}, 32'(A3), 32'(a));
      chk({tag, ".wd3"}, WD3, d);
    end
  endtask

  task automatic chk_fwd1(input string tag, input logic hit, input logic [31:0] d);
    chk({tag, ".fwd1_hit"}, 32'(fwd1_hit), 32'(hit));
    chk({tag, ".fwd1_data"}, fwd1_data, d);
  endtask

  task automatic chk_fwd2(input string tag, input logic hit, input logic [31:0] d);
    chk({tag, ".fwd2_hit"}, 32'(fwd2_hit), 32'(hit));
    chk({tag, ".fwd2_data"}, fwd2_data, d);
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we   = we;
    pipe_addr = a;
    pipe_data = d;
  endtask

  task automatic drive_sec(input logic v, input logic [4:0] a, input logic [31:0] d);
    sec_valid = v;
    sec_addr  = a;
    sec_data  = d;
  endtask

  initial begin
    RST = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_sec(1'b0, 5'd0, 32'h0);
    RA1 = 5'd0;
    RA2 = 5'd0;
    #12 RST = 1'b1;
    #1;

    // Reset state
    chk("rst.pending", 32'(pending), 32'h0);
    chk("rst.we3", 32'(WE3), 32'h0);
    chk("rst.a3", 32'(A3), 32'h0);
    chk("rst.wd3", WD3, 32'h0);
    chk("rst.sec_ready", 32'(sec_ready), 32'h1);
    chk("rst.idle", 32'(idle), 32'h1);
    chk_fwd1("rst", 1'b0, 32'h0);

    // Fill three entries behind a busy pipe, then async reset mid-operation
    drive_pipe(1'b1, 5'd1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive_sec(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      tick();
    end
    chk("fill3.pending", 32'(pending), 32'h3);
    drive_sec(1'b0, 5'd0, 32'h0);
    drive_pipe(1'b0, 5'd0, 32'h0);
    RA1 = 5'd10;
    RST = 1'b0;
    #1;
    chk("midrst.pending", 32'(pending), 32'h0);
    chk("midrst.we3", 32'(WE3), 32'h0);
    chk("midrst.sec_ready", 32'(sec_ready), 32'h1);
    chk("midrst.idle", 32'(idle), 32'h1);
    chk_fwd1("midrst", 1'b0, 32'h0);
    #1 RST = 1'b1;

    // Pipe-only write and forwarding from WD3
    drive_pipe(1'b1, 5'd5, 32'hDEAD);
    RA1 = 5'd5;
    tick();
    chk_wb("pipe5", 1'b1, 5'd5, 32'hDEAD);
    chk_fwd1("pipe5", 1'b1, 32'hDEAD);
    drive_pipe(1'b1, 5'd0, 32'h1234);
    tick();
    chk_wb("pipe0", 1'b0, 5'd0, 32'h0);
    chk("pipe0.a3_hold", 32'(A3), 32'h5);
    chk("pipe0.wd3_hold", WD3, 32'hDEAD);
    chk_fwd1("pipe0", 1'b0, 32'h0);

    // Contention: r7 waits out three busy pipe cycles
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_sec(1'b1, 5'd7, 32'h11);
    RA2 = 5'd7;
    tick();
    drive_sec(1'b0, 5'd0, 32'h0);
    chk("cont.pending", 32'(pending), 32'h1);
    chk_fwd2("cont.fifo", 1'b1, 32'h11);
    for (int i = 0; i < 3; i++) begin
      drive_pipe(1'b1, 5'(2 + i), 32'h22 + 32'(i) * 32'h11);
      tick();
      chk("cont.busy.pending", 32'(pending), 32'h1);
    end
    chk_wb("cont.busy", 1'b1, 5'd4, 32'h44);
    drive_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("cont.r7", 1'b1, 5'd7, 32'h11);
    chk("cont.r7.pending", 32'(pending), 32'h0);
    chk("cont.r7.idle", 32'(idle), 32'h0);
    tick();
    chk_wb("cont.after", 1'b0, 5'd0, 32'h0);
    chk("cont.after.idle", 32'(idle), 32'h1);

    // Full buffer and backpressure
    drive_pipe(1'b1, 5'd1, 32'h55);
    for (int i = 0; i < 4; i++) begin
      chk("full.ready_pre", 32'(sec_ready), 32'h1);
      drive_sec(1'b1, 5'(20 + i), 32'hA0 + 32'(i));
      tick();
    end
    chk("full.pending", 32'(pending), 32'h4);
    chk("full.ready", 32'(sec_ready), 32'h0);
    drive_sec(1'b1, 5'd24, 32'hA4);
    tick();
    chk("full.hold.pending", 32'(pending), 32'h4);
    chk("full.hold.ready", 32'(sec_ready), 32'h0);
    drive_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("full.pop20", 1'b1, 5'd20, 32'hA0);
    chk("full.pop20.pending", 32'(pending), 32'h3);
    chk("full.pop20.ready", 32'(sec_ready), 32'h1);
    tick();
    drive_sec(1'b0, 5'd0, 32'h0);
    chk_wb("full.pop21", 1'b1, 5'd21, 32'hA1);
    chk("full.pop21.pending", 32'(pending), 32'h3);
    tick();
    chk_wb("full.pop22", 1'b1, 5'd22, 32'hA2);
    chk("full.pop22.pending", 32'(pending), 32'h2);
    tick();
    chk_wb("full.pop23", 1'b1, 5'd23, 32'hA3);
    tick();
    chk_wb("full.pop24", 1'b1, 5'd24, 32'hA4);
    chk("full.pop24.pending", 32'(pending), 32'h0);
    tick();
    chk_wb("full.drained", 1'b0, 5'd0, 32'h0);
    chk("full.drained.idle", 32'(idle), 32'h1);

    // WAW kill of a buffered r9
    drive_pipe(1'b1, 5'd1, 32'h66);
    drive_sec(1'b1, 5'd9, 32'h1);
    tick();
    drive_sec(1'b1, 5'd3, 32'h2);
    tick();
    drive_sec(1'b0, 5'd0, 32'h0);
    chk("waw.pending", 32'(pending), 32'h2);
    drive_pipe(1'b1, 5'd9, 32'h5);
    RA1 = 5'd9;
    tick();
    chk_wb("waw.pipe9", 1'b1, 5'd9, 32'h5);
    chk("waw.pipe9.pending", 32'(pending), 32'h2);
    chk_fwd1("waw.pipe9", 1'b1, 32'h5);
    drive_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("waw.bubble", 1'b0, 5'd0, 32'h0);
    chk("waw.bubble.pending", 32'(pending), 32'h1);
    chk_fwd1("waw.bubble", 1'b0, 32'h0);
    tick();
    chk_wb("waw.r3", 1'b1, 5'd3, 32'h2);
    chk("waw.r3.pending", 32'(pending), 32'h0);

    // Same-cycle sec r9 and pipe r9: only the pipe value commits
    drive_sec(1'b1, 5'd9, 32'h77);
    drive_pipe(1'b1, 5'd9, 32'h88);
    tick();
    drive_sec(1'b0, 5'd0, 32'h0);
    drive_pipe(1'b0, 5'd0, 32'h0);
    chk_wb("same.pipe9", 1'b1, 5'd9, 32'h88);
    chk("same.pending", 32'(pending), 32'h1);
    chk_fwd1("same.pipe9", 1'b1, 32'h88);
    tick();
    chk_wb("same.killed", 1'b0, 5'd0, 32'h0);
    chk("same.killed.pending", 32'(pending), 32'h0);
    tick();
    chk_wb("same.after", 1'b0, 5'd0, 32'h0);
    chk("same.after.idle", 32'(idle), 32'h1);

    // Forward priority: r4 C, A, B buffered; newest live entry wins over WD3
    drive_pipe(1'b1, 5'd1, 32'h5A);
    RA2 = 5'd4;
    drive_sec(1'b1, 5'd4, 32'hC);
    tick();
    drive_sec(1'b1, 5'd4, 32'hA);
    tick();
    drive_sec(1'b1, 5'd4, 32'hB);
    tick();
    drive_sec(1'b0, 5'd0, 32'h0);
    chk("prio.pending", 32'(pending), 32'h3);
    chk_fwd2("prio.fifo", 1'b1, 32'hB);
    drive_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("prio.popC", 1'b1, 5'd4, 32'hC);
    chk_fwd2("prio.popC", 1'b1, 32'hB);
    tick();
    chk_wb("prio.popA", 1'b1, 5'd4, 32'hA);
    chk_fwd2("prio.popA", 1'b1, 32'hB);
    tick();
    chk_wb("prio.popB", 1'b1, 5'd4, 32'hB);
    chk_fwd2("prio.popB", 1'b1, 32'hB);
    tick();
    chk_fwd2("prio.empty", 1'b0, 32'h0);

    // Walk pointers to slot 3 so the next pair wraps (head 3, tail 1)
    for (int i = 0; i < 3; i++) begin
      drive_sec(1'b1, 5'(13 + i), 32'hD0 + 32'(i));
      tick();
    end
    drive_sec(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("walk.r15", 1'b1, 5'd15, 32'hD2);
    chk("walk.pending", 32'(pending), 32'h0);
    drive_pipe(1'b1, 5'd1, 32'h5B);
    RA1 = 5'd4;
    drive_sec(1'b1, 5'd4, 32'hA);
    tick();
    drive_sec(1'b1, 5'd4, 32'hB);
    tick();
    drive_sec(1'b0, 5'd0, 32'h0);
    chk("wrap.pending", 32'(pending), 32'h2);
    chk_fwd2("wrap", 1'b1, 32'hB);
    chk_fwd1("wrap", 1'b1, 32'hB);
    RA1 = 5'd0;
    #1;
    chk_fwd1("wrap.ra0", 1'b0, 32'h0);
    drive_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk_wb("wrap.popA", 1'b1, 5'd4, 32'hA);
    chk_fwd2("wrap.popA", 1'b1, 32'hB);
    tick();
    chk_wb("wrap.popB", 1'b1, 5'd4, 32'hB);
    tick();
    chk("wrap.idle", 32'(idle), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
